// File: rtl/oric_sdram_bridge.sv
// ---------------------------------------------------------------------------
// oric_sdram_bridge
//
// Bridges the Oric's asynchronous-looking RAM bus (sampled in the 72 MHz SDRAM
// clock domain) onto a toggle-handshake SDRAM port. A rising read or write
// select, or a read-address change, starts one SDRAM access. A request is a
// toggle of port_req. The access completes when port_ack equals port_req.
//
// Ports
//   clk          SDRAM-side clock, all logic on its rising edge
//   reset        synchronous active-high reset
//   ram_cs/oe/we Oric RAM select, read enable, write enable
//   ram_ad       Oric byte address
//   ram_d        Oric write data
//   ram_q        read data returned to the Oric (registered, holds last value)
//   port_req     toggle request to the SDRAM port
//   port_ack     toggle acknowledge from the SDRAM port
//   port_a       latched byte address
//   port_ds      byte strobes (11 read, 01 even-byte write, 10 odd-byte write)
//   port_we      latched write flag
//   port_d       write data, the byte replicated into both halves
//   port_q       SDRAM read word
//   busy         access outstanding or a trigger pending
//   timeout_err  sticky: some access was abandoned for lack of an ack
//
// Parameter
//   TIMEOUT      WAIT_ACK cycles before an access is abandoned (2..255)
// ---------------------------------------------------------------------------
module oric_sdram_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ram_cs,
  input  logic        ram_oe,
  input  logic        ram_we,
  input  logic [15:0] ram_ad,
  input  logic [7:0]  ram_d,
  output logic [7:0]  ram_q,
  output logic        port_req,
  input  logic        port_ack,
  output logic [15:0] port_a,
  output logic [1:0]  port_ds,
  output logic        port_we,
  output logic [15:0] port_d,
  input  logic [15:0] port_q,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_t;

  state_t      state_q, state_d;

  // Bus history for edge / address-change detection
  logic        rd_old_q;
  logic        wr_old_q;
  logic [15:0] ad_old_q;

  // Datapath registers and their next-state values
  logic        pending_q,     pending_d;
  logic [7:0]  timer_q,       timer_d;
  logic [7:0]  rdata_q,       rdata_d;
  logic        port_req_q,    port_req_d;
  logic [15:0] port_a_q,      port_a_d;
  logic [1:0]  port_ds_q,     port_ds_d;
  logic        port_we_q,     port_we_d;
  logic [15:0] port_d_q,      port_d_d;
  logic        busy_q,        busy_d;
  logic        timeout_err_q, timeout_err_d;

  logic        rd_s;
  logic        wr_s;
  logic        trigger_s;
  logic        start_s;
  logic        ack_match_s;
  logic [7:0]  timer_inc_s;
  logic        expire_s;

  // Byte strobes for an access: both bytes on read, one byte on write
  function automatic logic [1:0] strobes(input logic we, input logic a0);
    logic [1:0] ds;
    if (!we) begin
      ds = 2'b11;
    end else if (a0) begin
      ds = 2'b10;
    end else begin
      ds = 2'b01;
    end
    return ds;
  endfunction

  assign rd_s        = ram_cs & ram_oe;
  assign wr_s        = ram_cs & ram_we;
  assign trigger_s   = (rd_s & ~rd_old_q) | (wr_s & ~wr_old_q) |
                       (rd_s & (ram_ad != ad_old_q));
  assign start_s     = trigger_s | pending_q;
  assign ack_match_s = (port_ack == port_req_q);
  assign timer_inc_s = timer_q + 8'd1;
  // Expiry is the TIMEOUT-th WAIT_ACK cycle without a matching ack
  assign expire_s    = ~ack_match_s & (timer_inc_s == TIMEOUT_C);

  // Bus history, refreshed every cycle; cleared so held inputs retrigger after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_old_q <= 1'b0;
      wr_old_q <= 1'b0;
      ad_old_q <= 16'h0000;
    end else begin
      rd_old_q <= rd_s;
      wr_old_q <= wr_s;
      ad_old_q <= ram_ad;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_WAIT_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_match_s || expire_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM output / datapath next-value logic
  always_comb begin
    pending_d     = pending_q;
    timer_d       = timer_q;
    rdata_d       = rdata_q;
    port_req_d    = port_req_q;
    port_a_d      = port_a_q;
    port_ds_d     = port_ds_q;
    port_we_d     = port_we_q;
    port_d_d      = port_d_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          // Inputs are sampled now, so a merged pending trigger uses current values.
          // Request = ~ack is a toggle while in sync and stays a real request
          // even if a stale ack toggle lands on this very cycle.
          port_a_d   = ram_ad;
          port_we_d  = ram_we;
          port_d_d   = {ram_d, ram_d};
          port_ds_d  = strobes(ram_we, ram_ad[0]);
          port_req_d = ~port_ack;
          pending_d  = 1'b0;
          timer_d    = 8'd0;
        end else begin
          // Track the ack so a late toggle from an abandoned access is absorbed
          port_req_d = port_ack;
        end
      end
      ST_WAIT_ACK: begin
        if (trigger_s) begin
          pending_d = 1'b1;
        end else begin
          pending_d = pending_q;
        end
        if (ack_match_s) begin
          if (!port_we_q) begin
            rdata_d = port_a_q[0] ? port_q[15:8] : port_q[7:0];
          end else begin
            rdata_d = rdata_q;
          end
        end else if (expire_s) begin
          timeout_err_d = 1'b1;
          port_req_d    = port_ack;
          if (!port_we_q) begin
            rdata_d = 8'hFF;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          timer_d = timer_inc_s;
        end
      end
      default: begin
        pending_d = 1'b0;
        timer_d   = 8'd0;
      end
    endcase
    busy_d = (state_d == ST_WAIT_ACK) | pending_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q     <= 1'b0;
      timer_q       <= 8'd0;
      rdata_q       <= 8'h00;
      port_req_q    <= port_ack;
      port_a_q      <= 16'h0000;
      port_ds_q     <= 2'b11;
      port_we_q     <= 1'b0;
      port_d_q      <= 16'h0000;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      timer_q       <= timer_d;
      rdata_q       <= rdata_d;
      port_req_q    <= port_req_d;
      port_a_q      <= port_a_d;
      port_ds_q     <= port_ds_d;
      port_we_q     <= port_we_d;
      port_d_q      <= port_d_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign ram_q       = rdata_q;
  assign port_req    = port_req_q;
  assign port_a      = port_a_q;
  assign port_ds     = port_ds_q;
  assign port_we     = port_we_q;
  assign port_d      = port_d_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_oric_sdram_bridge.sv
// ---------------------------------------------------------------------------
// tb_oric_sdram_bridge
//
// Directed bench for oric_sdram_bridge built with TIMEOUT=16. Inputs are
// driven and outputs sampled 1 ns after each rising edge; the SDRAM side is
// played by hand, with acknowledge values chosen by the bench.
// ---------------------------------------------------------------------------
module tb_oric_sdram_bridge;

  logic        clk;
  logic        reset;
  logic        ram_cs;
  logic        ram_oe;
  logic        ram_we;
  logic [15:0] ram_ad;
  logic [7:0]  ram_d;
  logic [7:0]  ram_q;
  logic        port_req;
  logic        port_ack;
  logic [15:0] port_a;
  logic [1:0]  port_ds;
  logic        port_we;
  logic [15:0] port_d;
  logic [15:0] port_q;
  logic        busy;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  oric_sdram_bridge #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .ram_cs      (ram_cs),
    .ram_oe      (ram_oe),
    .ram_we      (ram_we),
    .ram_ad      (ram_ad),
    .ram_d       (ram_d),
    .ram_q       (ram_q),
    .port_req    (port_req),
    .port_ack    (port_ack),
    .port_a      (port_a),
    .port_ds     (port_ds),
    .port_we     (port_we),
    .port_d      (port_d),
    .port_q      (port_q),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b1;
    ram_cs   = 1'b0;
    ram_oe   = 1'b0;
    ram_we   = 1'b0;
    ram_ad   = 16'h0000;
    ram_d    = 8'h00;
    port_ack = 1'b0;
    port_q   = 16'h0000;
    ticks(3);

    // Reset state
    chk("rst_req",   32'(port_req),    32'h0);
    chk("rst_q",     32'(ram_q),       32'h00);
    chk("rst_busy",  32'(busy),        32'h0);
    chk("rst_terr",  32'(timeout_err), 32'h0);
    chk("rst_a",     32'(port_a),      32'h0000);
    chk("rst_we",    32'(port_we),     32'h0);
    chk("rst_d",     32'(port_d),      32'h0000);
    reset = 1'b0;
    tick();

    // Read of odd address, ack 6 cycles after the request
    ram_cs = 1'b1; ram_oe = 1'b1; ram_ad = 16'h1235;
    tick();
    chk("rd_req",    32'(port_req), 32'h1);
    chk("rd_busy",   32'(busy),     32'h1);
    chk("rd_a",      32'(port_a),   32'h1235);
    chk("rd_ds",     32'(port_ds),  32'h3);
    chk("rd_we",     32'(port_we),  32'h0);
    ticks(5);
    chk("rd_wait",   32'(busy),     32'h1);
    chk("rd_q_old",  32'(ram_q),    32'h00);
    port_ack = 1'b1; port_q = 16'hAB12;
    tick();
    chk("rd_q",      32'(ram_q),    32'hAB);
    chk("rd_done",   32'(busy),     32'h0);
    tick();
    chk("rd_hold",   32'(port_req), 32'h1);
    ram_cs = 1'b0; ram_oe = 1'b0;
    tick();

    // Write of even address: single toggle, low-byte strobe
    ram_cs = 1'b1; ram_we = 1'b1; ram_ad = 16'h0400; ram_d = 8'h5A;
    tick();
    chk("wr_req",    32'(port_req), 32'h0);
    chk("wr_we",     32'(port_we),  32'h1);
    chk("wr_ds",     32'(port_ds),  32'h1);
    chk("wr_d",      32'(port_d),   32'h5A5A);
    chk("wr_a",      32'(port_a),   32'h0400);
    tick();
    port_ack = 1'b0;
    tick();
    chk("wr_done",   32'(busy),     32'h0);
    chk("wr_q_keep", 32'(ram_q),    32'hAB);
    ticks(2);
    chk("wr_one",    32'(port_req), 32'h0);
    ram_cs = 1'b0; ram_we = 1'b0;
    tick();

    // Odd-byte write strobe
    ram_cs = 1'b1; ram_we = 1'b1; ram_ad = 16'h0401; ram_d = 8'hC7;
    tick();
    chk("wr2_ds",    32'(port_ds),  32'h2);
    chk("wr2_d",     32'(port_d),   32'hC7C7);
    port_ack = 1'b1;
    tick();
    chk("wr2_done",  32'(busy),     32'h0);
    ram_cs = 1'b0; ram_we = 1'b0;
    tick();

    // Chip select low: no triggers
    ram_oe = 1'b1; ram_ad = 16'h3000;
    tick();
    ram_ad = 16'h3001;
    tick();
    chk("cs_off",    32'(busy),     32'h0);
    chk("cs_off_q",  32'(ram_q),    32'hAB);
    ram_oe = 1'b0;
    tick();

    // Address change during a held read -> pending, second request at new address
    ram_cs = 1'b1; ram_oe = 1'b1; ram_ad = 16'h2000;
    tick();
    chk("ac_req1",   32'(port_req), 32'h0);
    ram_ad = 16'h2001;
    tick();
    chk("ac_stable", 32'(port_a),   32'h2000);
    tick();
    port_ack = 1'b0; port_q = 16'h3344;
    tick();
    chk("ac_q1",     32'(ram_q),    32'h44);
    chk("ac_pend",   32'(busy),     32'h1);
    chk("ac_nochg",  32'(port_req), 32'h0);
    tick();
    chk("ac_req2",   32'(port_req), 32'h1);
    chk("ac_a2",     32'(port_a),   32'h2001);
    port_ack = 1'b1; port_q = 16'h7788;
    tick();
    chk("ac_q2",     32'(ram_q),    32'h77);
    chk("ac_done",   32'(busy),     32'h0);
    ram_cs = 1'b0; ram_oe = 1'b0;
    tick();

    // No ack: abandon after 16 WAIT_ACK cycles, then a normal read
    ram_cs = 1'b1; ram_oe = 1'b1; ram_ad = 16'h0010;
    tick();
    chk("to_req",    32'(port_req), 32'h0);
    ticks(15);
    chk("to_early",  32'(timeout_err), 32'h0);
    chk("to_busy",   32'(busy),        32'h1);
    tick();
    chk("to_err",    32'(timeout_err), 32'h1);
    chk("to_q",      32'(ram_q),       32'hFF);
    chk("to_sync",   32'(port_req),    32'h1);
    chk("to_idle",   32'(busy),        32'h0);
    ram_ad = 16'h0011;
    tick();
    chk("to_req2",   32'(port_req), 32'h0);
    port_ack = 1'b0; port_q = 16'hC3D4;
    tick();
    chk("to_q2",     32'(ram_q),       32'hC3);
    chk("to_sticky", 32'(timeout_err), 32'h1);
    ram_cs = 1'b0; ram_oe = 1'b0;
    tick();

    // Reset two cycles into WAIT_ACK with ack high
    port_ack = 1'b1;
    tick();
    ram_cs = 1'b1; ram_oe = 1'b1; ram_ad = 16'h0100;
    tick();
    chk("ra_req",    32'(port_req), 32'h0);
    ticks(2);
    reset = 1'b1;
    tick();
    chk("ra_req_r",  32'(port_req),    32'h1);
    chk("ra_busy",   32'(busy),        32'h0);
    chk("ra_q",      32'(ram_q),       32'h00);
    chk("ra_terr",   32'(timeout_err), 32'h0);
    reset = 1'b0; ram_cs = 1'b0; ram_oe = 1'b0;
    tick();
    port_ack = 1'b0; port_q = 16'hEEEE;
    ticks(2);
    chk("ra_ign_b",  32'(busy),  32'h0);
    chk("ra_ign_q",  32'(ram_q), 32'h00);

    // Trigger on the reset cycle is ignored; held inputs trigger afterwards
    reset = 1'b1; ram_cs = 1'b1; ram_oe = 1'b1; ram_ad = 16'h0003;
    tick();
    chk("rt_busy",   32'(busy),     32'h0);
    chk("rt_req",    32'(port_req), 32'h0);
    reset = 1'b0;
    tick();
    chk("rt_go",     32'(port_req), 32'h1);
    chk("rt_a",      32'(port_a),   32'h0003);
    port_ack = 1'b1; port_q = 16'h1100;
    tick();
    chk("rt_q",      32'(ram_q),    32'h11);
    ram_cs = 1'b0; ram_oe = 1'b0;
    tick();

    // Trigger coincident with ack: two toggles total, second one cycle later
    ram_cs = 1'b1; ram_oe = 1'b1; ram_ad = 16'h0040;
    tick();
    chk("co_req1",   32'(port_req), 32'h0);
    tick();
    port_ack = 1'b0; port_q = 16'h0099; ram_ad = 16'h0041;
    tick();
    chk("co_q1",     32'(ram_q),    32'h99);
    chk("co_same",   32'(port_req), 32'h0);
    chk("co_pend",   32'(busy),     32'h1);
    tick();
    chk("co_req2",   32'(port_req), 32'h1);
    chk("co_a2",     32'(port_a),   32'h0041);
    port_ack = 1'b1; port_q = 16'h5500;
    tick();
    chk("co_q2",     32'(ram_q),    32'h55);
    ticks(2);
    chk("co_two",    32'(port_req), 32'h1);
    chk("co_idle",   32'(busy),     32'h0);
    ram_cs = 1'b0; ram_oe = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
